// File: rtl/id_stage.sv
// Instruction-decode stage: IF/ID latch, opcode decode, 32x32 register file and registered ID/EX bundle.
// Optional macro ID_WB_BYPASS_EN forwards same-cycle write-back data into the decode reads.
module id_stage #(
   parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic [31:0] NEXT_INST_ADR,
   input  logic [31:0] CUR_INST,
   input  logic        STALL,
   input  logic        FLUSH,
   input  logic        WB_REG_WRITE,
   input  logic [4:0]  WB_WRITE_REG,
   input  logic [31:0] WB_WRITE_DATA,
   output logic        EX_VALID,
   output logic [31:0] EX_PC4,
   output logic [31:0] EX_READ_DATA_1,
   output logic [31:0] EX_READ_DATA_2,
   output logic [31:0] EX_SIGN_EXT,
   output logic [4:0]  EX_RS,
   output logic [4:0]  EX_RT,
   output logic [4:0]  EX_RD,
   output logic        EX_REG_DST,
   output logic        EX_ALU_SRC,
   output logic        EX_MEM_TO_REG,
   output logic        EX_REG_WRITE,
   output logic        EX_MEM_READ,
   output logic        EX_MEM_WRITE,
   output logic        EX_BRANCH,
   output logic [1:0]  EX_ALU_OP
);

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;

   typedef struct packed {
      logic        valid;
      logic [31:0] pc4;
      logic [31:0] read_data_1;
      logic [31:0] read_data_2;
      logic [31:0] sign_ext;
      logic [4:0]  rs;
      logic [4:0]  rt;
      logic [4:0]  rd;
      logic        reg_dst;
      logic        alu_src;
      logic        mem_to_reg;
      logic        reg_write;
      logic        mem_read;
      logic        mem_write;
      logic        branch;
      logic [1:0]  alu_op;
   } id_ex_t;

   logic [31:0] ifid_inst;
   logic [31:0] ifid_pc4;
   logic        ifid_valid;
   logic [31:0] rf [32];
   logic [31:0] rs_data;
   logic [31:0] rt_data;
   id_ex_t      decoded;
   id_ex_t      ex_q;

   // Flush squashes the latch even when the hazard unit also asks for a stall.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         ifid_inst  <= NOP_INST;
         ifid_pc4   <= '0;
         ifid_valid <= 1'b0;
      end else if (FLUSH) begin
         ifid_inst  <= NOP_INST;
         ifid_pc4   <= '0;
         ifid_valid <= 1'b0;
      end else if (!STALL) begin
         ifid_inst  <= CUR_INST;
         ifid_pc4   <= NEXT_INST_ADR;
         ifid_valid <= 1'b1;
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         for (int i = 0; i < 32; i++) rf[i] <= '0;
      end else if (WB_REG_WRITE && (WB_WRITE_REG != 5'd0)) begin
         rf[WB_WRITE_REG] <= WB_WRITE_DATA;
      end
   end

   always_comb begin
      rs_data = (ifid_inst[25:21] == 5'd0) ? 32'd0 : rf[ifid_inst[25:21]];
      rt_data = (ifid_inst[20:16] == 5'd0) ? 32'd0 : rf[ifid_inst[20:16]];
`ifdef ID_WB_BYPASS_EN
      if (WB_REG_WRITE && (WB_WRITE_REG != 5'd0) && (WB_WRITE_REG == ifid_inst[25:21]))
         rs_data = WB_WRITE_DATA;
      if (WB_REG_WRITE && (WB_WRITE_REG != 5'd0) && (WB_WRITE_REG == ifid_inst[20:16]))
         rt_data = WB_WRITE_DATA;
`endif
   end

   // Unknown opcodes fall through with every control low but still count as valid.
   always_comb begin
      decoded             = '0;
      decoded.valid       = 1'b1;
      decoded.pc4         = ifid_pc4;
      decoded.read_data_1 = rs_data;
      decoded.read_data_2 = rt_data;
      decoded.sign_ext    = {{16{ifid_inst[15]}}, ifid_inst[15:0]};
      decoded.rs          = ifid_inst[25:21];
      decoded.rt          = ifid_inst[20:16];
      decoded.rd          = ifid_inst[15:11];
      case (ifid_inst[31:26])
         OP_RTYPE: begin
            decoded.reg_dst   = 1'b1;
            decoded.reg_write = 1'b1;
            decoded.alu_op    = 2'b10;
         end
         OP_LW: begin
            decoded.alu_src    = 1'b1;
            decoded.mem_to_reg = 1'b1;
            decoded.reg_write  = 1'b1;
            decoded.mem_read   = 1'b1;
         end
         OP_SW: begin
            decoded.alu_src   = 1'b1;
            decoded.mem_write = 1'b1;
         end
         OP_BEQ: begin
            decoded.branch = 1'b1;
            decoded.alu_op = 2'b01;
         end
         OP_ADDI: begin
            decoded.alu_src   = 1'b1;
            decoded.reg_write = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         ex_q <= '0;
      end else if (STALL || !ifid_valid) begin
         ex_q <= '0;
      end else begin
         ex_q <= decoded;
      end
   end

   assign EX_VALID       = ex_q.valid;
   assign EX_PC4         = ex_q.pc4;
   assign EX_READ_DATA_1 = ex_q.read_data_1;
   assign EX_READ_DATA_2 = ex_q.read_data_2;
   assign EX_SIGN_EXT    = ex_q.sign_ext;
   assign EX_RS          = ex_q.rs;
   assign EX_RT          = ex_q.rt;
   assign EX_RD          = ex_q.rd;
   assign EX_REG_DST     = ex_q.reg_dst;
   assign EX_ALU_SRC     = ex_q.alu_src;
   assign EX_MEM_TO_REG  = ex_q.mem_to_reg;
   assign EX_REG_WRITE   = ex_q.reg_write;
   assign EX_MEM_READ    = ex_q.mem_read;
   assign EX_MEM_WRITE   = ex_q.mem_write;
   assign EX_BRANCH      = ex_q.branch;
   assign EX_ALU_OP      = ex_q.alu_op;

endmodule
